// File: rtl/register_file.sv
// register_file: 32-entry two-read one-write register file, r0 hardwired to zero, write-through bypass
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address_one,
  input  logic [ADDR_WIDTH-1:0] read_address_two,
  output logic [DATA_WIDTH-1:0] read_data_one,
  output logic [DATA_WIDTH-1:0] read_data_two
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [N];
  logic [DATA_WIDTH-1:0] regs_d [N];
  logic                  wr;
  assign wr = write_enable && write_address != '0 && !reset;
  // next-state: apply the pending write, keep r0 pinned at zero
  always_comb begin
    regs_d = regs_q;
    if (wr) regs_d[write_address] = write_data;
    regs_d[0] = '0;
  end
  // storage, cleared asynchronously so a reset drops any write on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
  // read ports: forced zero in reset, bypass the in-flight write, r0 always zero
  always_comb begin
    read_data_one = reset ? '0
                  : (wr && write_address == read_address_one) ? write_data
                  : (read_address_one == '0) ? '0 : regs_q[read_address_one];
    read_data_two = reset ? '0
                  : (wr && write_address == read_address_two) ? write_data
                  : (read_address_two == '0) ? '0 : regs_q[read_address_two];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [4:0]  write_address = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_address_one = '0;
  logic [4:0]  read_address_two = '0;
  logic [31:0] read_data_one;
  logic [31:0] read_data_two;
  int checks = 0;
  int errors = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_data(write_data),
    .read_address_one(read_address_one),
    .read_address_two(read_address_two),
    .read_data_one(read_data_one),
    .read_data_two(read_data_two)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    write_enable = 1'b1;
    write_address = a;
    write_data = d;
    @(negedge clock);
    write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    read_address_one = a1;
    read_address_two = a2;
    #1;
    chk({tag, "_p1"}, read_data_one, e1);
    chk({tag, "_p2"}, read_data_two, e2);
  endtask

  initial begin
    // write held across an edge while in reset: ignored, no bypass
    write_enable = 1'b1;
    write_address = 5'd3;
    write_data = 32'h0000_0055;
    @(negedge clock);
    rd("rst_bypass", 5'd3, 5'd3, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    write_enable = 1'b0;
    rd("rst_write_lost", 5'd3, 5'd3, 32'h0, 32'h0);
    // every address reads zero after reset
    for (int a = 0; a < 32; a++)
      rd("reset_all", 5'(a), 5'(31 - a), 32'h0, 32'h0);
    // basic write and neighbours
    wr(5'd5, 32'hDEAD_BEEF);
    rd("r5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rd("r4_r6", 5'd4, 5'd6, 32'h0, 32'h0);
    // write to r0: no bypass during, nothing stored after
    @(negedge clock);
    write_enable = 1'b1;
    write_address = 5'd0;
    write_data = 32'h1234_5678;
    rd("r0_during", 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clock);
    write_enable = 1'b0;
    rd("r0_after", 5'd0, 5'd0, 32'h0, 32'h0);
    // bypass on both ports, then per-port independence
    wr(5'd7, 32'h0000_0001);
    rd("r7_old", 5'd7, 5'd7, 32'h0000_0001, 32'h0000_0001);
    write_enable = 1'b1;
    write_address = 5'd7;
    write_data = 32'hCAFE_F00D;
    rd("bypass_both", 5'd7, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    rd("bypass_one", 5'd7, 5'd5, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    rd("bypass_two", 5'd4, 5'd7, 32'h0, 32'hCAFE_F00D);
    @(negedge clock);
    write_enable = 1'b0;
    rd("r7_after", 5'd7, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    // disabled writes leave the register alone
    wr(5'd9, 32'h0000_0099);
    write_enable = 1'b0;
    write_address = 5'd9;
    write_data = 32'hFFFF_FFFF;
    rd("we0_during", 5'd9, 5'd9, 32'h0000_0099, 32'h0000_0099);
    repeat (3) @(negedge clock);
    rd("we0_after", 5'd9, 5'd9, 32'h0000_0099, 32'h0000_0099);
    // fill r1..r31 with their index
    for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
    for (int a = 0; a < 32; a++)
      rd("fill", 5'(a), 5'(31 - a), 32'(a), 32'(31 - a));
    // asynchronous reset mid-cycle clears everything immediately
    @(negedge clock);
    #2;
    reset = 1'b1;
    for (int a = 0; a < 32; a++)
      rd("async_rst", 5'(a), 5'(31 - a), 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    rd("rst_release", 5'd31, 5'd1, 32'h0, 32'h0);
    wr(5'd3, 32'hA5A5_A5A5);
    for (int a = 0; a < 32; a++)
      rd("post_rst", 5'(a), 5'(31 - a),
         (a == 3) ? 32'hA5A5_A5A5 : 32'h0,
         (a == 28) ? 32'hA5A5_A5A5 : 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of each register and of the data ports.
REQ-002 Parameter ADDR_WIDTH, 5, width of each register address (2^ADDR_WIDTH = 32 registers).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 write_enable  input  1  commit write_data to write_address on next rising clock edge when high.
REQ-006 write_address  input  ADDR_WIDTH  destination register index.
REQ-007 write_data  input  DATA_WIDTH  writeback value (driven by the writeback-select mux32 output).
REQ-008 read_address_one  input  ADDR_WIDTH  source register index, port one (rs).
REQ-009 read_address_two  input  ADDR_WIDTH  source register index, port two (rt).
REQ-010 read_data_one  output  DATA_WIDTH  contents of register read_address_one.
REQ-011 read_data_two  output  DATA_WIDTH  contents of register read_address_two.

Function
REQ-012 Storage SHALL be 32 registers of DATA_WIDTH bits, indices 0..31.
REQ-013 Register 0 SHALL read as 0 at all times; writes to index 0 SHALL be discarded with no side effect.
REQ-014 Writes SHALL be synchronous: on a rising edge with write_enable=1, reset=0, write_address!=0, register[write_address] <= write_data.
REQ-015 write_enable=0 SHALL leave all registers unchanged, regardless of write_address/write_data.
REQ-016 Reads SHALL be combinational: read_data_* reflect addressed register in the same cycle, zero clock latency.
REQ-017 Write-through bypass: when write_enable=1, write_address!=0, and write_address equals a read address, that read port SHALL output write_data in the same cycle, before the edge.
REQ-018 Bypass SHALL apply independently per port; both ports hitting the write address SHALL both return write_data.
REQ-019 Bypass SHALL NOT apply for address 0; read of index 0 returns 0 even during a write to index 0.
REQ-020 Both read ports SHALL read the same address simultaneously with identical results.
REQ-021 Only one write per cycle; no write-collision arbitration required.
REQ-022 Read outputs SHALL contain no X when all inputs are known.

Reset
REQ-023 Asserting reset SHALL clear registers 1..31 to 0 immediately, without waiting for a clock edge.
REQ-024 While reset is high, writes SHALL be ignored and bypass disabled; both read ports SHALL output 0 for every address.
REQ-025 A write in flight on the edge where reset rises SHALL be lost; after reset deasserts, first edge with write_enable=1 performs a normal write.
REQ-026 Reset deassertion SHALL NOT by itself modify any register.

Verification
REQ-027 Reset, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-028 Write 0xDEADBEEF to r5 (enable=1, one edge), read r5 on both ports next cycle -> 0xDEADBEEF on both; r4 and r6 still 0.
REQ-029 Write 0x12345678 to r0, then read r0 -> 0x00000000; during the write cycle read r0 -> 0x00000000 (no bypass).
REQ-030 r7=0x00000001 stored; same cycle drive write r7=0xCAFEF00D, read_address_one=7, read_address_two=7 -> both outputs 0xCAFEF00D before the edge, register holds 0xCAFEF00D after.
REQ-031 write_enable=0, write_address=9, write_data=0xFFFFFFFF for 3 edges -> r9 remains at prior value.
REQ-032 Fill r1..r31 with value equal to index, assert reset mid-cycle between edges -> all reads 0 immediately; deassert, write r3=0xA5A5A5A5 -> r3=0xA5A5A5A5, all others 0.
